// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and helpers for the EX-stage forwarding scoreboard.
package fwd_pkg;

    // Select code meaning "read the register file".
    localparam int unsigned SEL_RF = 0;

    // Widest register address an entry can hold; narrower addresses are zero-extended.
    localparam int unsigned RW_MAX = 8;

    // One in-flight writer tracked in the shadow pipeline.
    typedef struct packed {
        logic              v;
        logic [RW_MAX-1:0] dest;
        logic              ld;
    } entry_t;

    // Width of a per-source select: 0 = register file, 1..depth = stage.
    function automatic int unsigned sel_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// EX-stage consumer request and forwarding/interlock response bundle.
interface fwd_scoreboard_if
    import fwd_pkg::*;
#(
    parameter int unsigned RW      = 4,
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned CNT_W   = 32
);
    localparam int unsigned SEL_W = sel_width(DEPTH);

    logic                     fwd_en;
    logic                     freeze;
    logic                     flush;
    logic                     cons_valid;
    logic [NUM_SRC*RW-1:0]    cons_src;
    logic [NUM_SRC-1:0]       cons_src_used;
    logic                     cons_wb_en;
    logic [RW-1:0]            cons_dest;
    logic                     cons_is_load;
    logic [NUM_SRC*SEL_W-1:0] sel;
    logic                     stall_req;
    logic [CNT_W-1:0]         stall_cnt;

    modport master (
        output fwd_en, freeze, flush, cons_valid, cons_src, cons_src_used,
               cons_wb_en, cons_dest, cons_is_load,
        input  sel, stall_req, stall_cnt
    );

    modport slave (
        input  fwd_en, freeze, flush, cons_valid, cons_src, cons_src_used,
               cons_wb_en, cons_dest, cons_is_load,
        output sel, stall_req, stall_cnt
    );

endinterface

// File: rtl/fwd_src_match.sv
// Resolves one source operand against every in-flight writer (youngest wins).
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int unsigned RW       = 4,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned LOAD_RDY = 2,
    parameter int unsigned SEL_W    = 2
) (
    input  logic               i_fwd_en,
    input  logic               i_cons_valid,
    input  logic               i_used,
    input  logic [RW-1:0]      i_src,
    input  entry_t [DEPTH:1]   i_ent,
    output logic [SEL_W-1:0]   o_sel_c,
    output logic               o_hazard_c
);

    logic             w_found;
    logic             w_ld;
    logic [SEL_W-1:0] w_kmin;

    // Scan oldest to youngest so the youngest match overwrites the rest.
    always_comb begin
        w_found = 1'b0;
        w_ld    = 1'b0;
        w_kmin  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (i_cons_valid && i_used && i_ent[k].v &&
                (i_ent[k].dest == RW_MAX'(i_src))) begin
                w_found = 1'b1;
                w_ld    = i_ent[k].ld;
                w_kmin  = SEL_W'(k);
            end
        end
    end

    // A too-young load or any match in interlock mode is a hazard; never fall back to older stages.
    always_comb begin
        o_sel_c    = SEL_W'(SEL_RF);
        o_hazard_c = 1'b0;
        if (w_found) begin
            if (!i_fwd_en) begin
                o_hazard_c = 1'b1;
            end else if (w_ld && (32'(w_kmin) < LOAD_RDY)) begin
                o_hazard_c = 1'b1;
            end else begin
                o_sel_c = w_kmin;
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// EX-stage forwarding/interlock unit: shadow writer pipeline, stall OR, stall counter.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int unsigned RW       = 4,
    parameter int unsigned NUM_SRC  = 3,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned LOAD_RDY = 2,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    fwd_scoreboard_if.slave  bus
);

    localparam int unsigned SEL_W = sel_width(DEPTH);

    entry_t [DEPTH:1]   r_ent;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_SRC-1:0] w_haz;
    logic [SEL_W-1:0]   w_sel [NUM_SRC];
    logic               w_stall;
    entry_t             w_new;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_src_match #(
            .RW       (RW),
            .DEPTH    (DEPTH),
            .LOAD_RDY (LOAD_RDY),
            .SEL_W    (SEL_W)
        ) u_match (
            .i_fwd_en     (bus.fwd_en),
            .i_cons_valid (bus.cons_valid),
            .i_used       (bus.cons_src_used[g]),
            .i_src        (bus.cons_src[g*RW +: RW]),
            .i_ent        (r_ent),
            .o_sel_c      (w_sel[g]),
            .o_hazard_c   (w_haz[g])
        );
    end

    // Flush squashes the EX instruction, so it can never request a stall.
    assign w_stall = (|w_haz) & ~bus.flush;

    // Pack per-source selects onto the bus.
    always_comb begin
        bus.sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            bus.sel[i*SEL_W +: SEL_W] = w_sel[i];
        end
    end

    // Entry that enters stage 1 when EX advances normally.
    always_comb begin
        w_new      = '0;
        w_new.v    = bus.cons_valid & bus.cons_wb_en;
        w_new.dest = RW_MAX'(bus.cons_dest);
        w_new.ld   = bus.cons_is_load;
    end

    // Shadow pipeline: bubble on flush/stall, oldest entry retires every unfrozen edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ent <= '0;
        end else if (!bus.freeze) begin
            r_ent[1] <= (bus.flush || w_stall) ? entry_t'('0) : w_new;
            for (int k = 2; k <= DEPTH; k++) begin
                r_ent[k] <= r_ent[k-1];
            end
        end
    end

    // Saturating count of unfrozen stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_stall && !bus.freeze && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_req = w_stall;
    assign bus.stall_cnt = r_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench: two builds (DEPTH=2/CNT_W=32 and DEPTH=3/CNT_W=3) share one stimulus stream.
module tb_fwd_scoreboard;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fwd_scoreboard_if #(.RW(4), .NUM_SRC(3), .DEPTH(2), .CNT_W(32)) bus_a ();
    fwd_scoreboard_if #(.RW(4), .NUM_SRC(3), .DEPTH(3), .CNT_W(3))  bus_b ();

    fwd_scoreboard #(.RW(4), .NUM_SRC(3), .DEPTH(2), .LOAD_RDY(2), .CNT_W(32)) u_dut_a (
        .clk (clk), .rst (rst), .bus (bus_a.slave));
    fwd_scoreboard #(.RW(4), .NUM_SRC(3), .DEPTH(3), .LOAD_RDY(2), .CNT_W(3)) u_dut_b (
        .clk (clk), .rst (rst), .bus (bus_b.slave));

    // Stimulus variables, fanned out to both builds.
    bit          t_rst, t_fwd_en, t_freeze, t_flush, t_valid, t_wb, t_ld;
    int unsigned t_dest;
    int unsigned t_src [3];
    bit [2:0]    t_used;

    assign rst = t_rst;
    assign bus_a.fwd_en = t_fwd_en;         assign bus_b.fwd_en = t_fwd_en;
    assign bus_a.freeze = t_freeze;         assign bus_b.freeze = t_freeze;
    assign bus_a.flush  = t_flush;          assign bus_b.flush  = t_flush;
    assign bus_a.cons_valid = t_valid;      assign bus_b.cons_valid = t_valid;
    assign bus_a.cons_wb_en = t_wb;         assign bus_b.cons_wb_en = t_wb;
    assign bus_a.cons_is_load = t_ld;       assign bus_b.cons_is_load = t_ld;
    assign bus_a.cons_dest = 4'(t_dest);    assign bus_b.cons_dest = 4'(t_dest);
    assign bus_a.cons_src_used = t_used;    assign bus_b.cons_src_used = t_used;
    assign bus_a.cons_src = {4'(t_src[2]), 4'(t_src[1]), 4'(t_src[0])};
    assign bus_b.cons_src = {4'(t_src[2]), 4'(t_src[1]), 4'(t_src[0])};

    // Reference model: list of in-flight writers per build, index 0 = youngest.
    typedef struct { bit v; int unsigned dest; bit ld; } wr_t;
    wr_t         pipe [2][3];
    longint      mcnt [2];
    int unsigned mdepth [2] = '{2, 3};
    int unsigned mlrdy  [2] = '{2, 2};
    longint      mmax   [2] = '{64'hFFFF_FFFF, 7};

    typedef struct {
        bit [5:0] sel_a;  bit st_a;  longint cnt_a;
        bit [5:0] sel_b;  bit st_b;  longint cnt_b;
        bit       hk;     bit [5:0] k_sel; bit k_st; longint k_cnt_a;
        bit       hkb;    longint k_cnt_b;
    } exp_t;
    exp_t sb [$];

    bit       k_en, kb_en, k_st;
    bit [5:0] k_sel;
    longint   k_cnt_a, k_cnt_b;

    int n_vec = 0;
    int n_mis = 0;

    function automatic void predict(input int inst, output bit [5:0] sel, output bit stall);
        bit haz = 0;
        sel = '0;
        for (int i = 0; i < 3; i++) begin
            int unsigned s = 0;
            bit found = 0;
            if (t_valid && t_used[i]) begin
                for (int k = 0; k < int'(mdepth[inst]); k++) begin
                    if (!found && pipe[inst][k].v && pipe[inst][k].dest == t_src[i]) begin
                        found = 1;
                        if (!t_fwd_en) haz = 1;
                        else if (pipe[inst][k].ld && (k + 1) < int'(mlrdy[inst])) haz = 1;
                        else s = k + 1;
                    end
                end
            end
            sel[2*i +: 2] = 2'(s);
        end
        stall = haz && !t_flush;
    endfunction

    function automatic void update(input int inst);
        bit [5:0] s;
        bit st;
        if (t_rst) begin
            for (int k = 0; k < 3; k++) pipe[inst][k] = '{v: 0, dest: 0, ld: 0};
            mcnt[inst] = 0;
        end else if (!t_freeze) begin
            predict(inst, s, st);
            if (st && mcnt[inst] < mmax[inst]) mcnt[inst]++;
            for (int k = int'(mdepth[inst]) - 1; k >= 1; k--) pipe[inst][k] = pipe[inst][k-1];
            if (t_flush || st) pipe[inst][0] = '{v: 0, dest: 0, ld: 0};
            else pipe[inst][0] = '{v: t_valid && t_wb, dest: t_dest, ld: t_ld};
        end
    endfunction

    // One clock: publish the expectation, then advance the model on the edge.
    task automatic cyc();
        exp_t e;
        bit [5:0] s;
        bit st;
        #1;
        if (!t_rst) begin
            predict(0, s, st);  e.sel_a = s;  e.st_a = st;  e.cnt_a = mcnt[0];
            predict(1, s, st);  e.sel_b = s;  e.st_b = st;  e.cnt_b = mcnt[1];
            e.hk = k_en;  e.k_sel = k_sel;  e.k_st = k_st;  e.k_cnt_a = k_cnt_a;
            e.hkb = kb_en;  e.k_cnt_b = k_cnt_b;
            sb.push_back(e);
        end
        k_en  = 0;
        kb_en = 0;
        @(posedge clk);
        update(0);
        update(1);
        @(negedge clk);
    endtask

    task automatic ex(input bit v, input bit wb, input int unsigned d, input bit ld,
                      input bit [2:0] used, input int unsigned s0, input int unsigned s1,
                      input int unsigned s2);
        t_valid = v;  t_wb = wb;  t_dest = d;  t_ld = ld;  t_used = used;
        t_src[0] = s0;  t_src[1] = s1;  t_src[2] = s2;
    endtask

    // Hand-derived expectation for build A in the next cycle.
    task automatic kset(input bit [5:0] sel, input bit st, input longint cnt);
        k_en = 1;  k_sel = sel;  k_st = st;  k_cnt_a = cnt;
    endtask

    task automatic cmp(input string nm, input longint got, input longint want);
        n_vec++;
        if (got != want) begin
            n_mis++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    // Monitor: pops one expectation per cycle, well before the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("sel_a",   longint'(bus_a.sel),       longint'(e.sel_a));
                cmp("stall_a", longint'(bus_a.stall_req), longint'(e.st_a));
                cmp("cnt_a",   longint'(bus_a.stall_cnt), e.cnt_a);
                cmp("sel_b",   longint'(bus_b.sel),       longint'(e.sel_b));
                cmp("stall_b", longint'(bus_b.stall_req), longint'(e.st_b));
                cmp("cnt_b",   longint'(bus_b.stall_cnt), e.cnt_b);
                if (e.hk) begin
                    cmp("k_sel_a",   longint'(bus_a.sel),       longint'(e.k_sel));
                    cmp("k_stall_a", longint'(bus_a.stall_req), longint'(e.k_st));
                    cmp("k_cnt_a",   longint'(bus_a.stall_cnt), e.k_cnt_a);
                end
                if (e.hkb) cmp("k_cnt_b", longint'(bus_b.stall_cnt), e.k_cnt_b);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        t_rst = 1;  t_fwd_en = 1;  t_freeze = 0;  t_flush = 0;
        k_en = 0;  kb_en = 0;  k_st = 0;  k_sel = '0;  k_cnt_a = 0;  k_cnt_b = 0;
        ex(0, 0, 0, 0, 3'b000, 0, 0, 0);
        @(negedge clk);
        cyc();
        cyc();
        t_rst = 0;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            kset(6'b000000, 0, 0);  kb_en = 1;  k_cnt_b = 0;
            cyc();
        end

        // ADD r3, then consumers one and two cycles later.
        ex(1, 1, 3, 0, 3'b000, 0, 0, 0);  kset(6'b000000, 0, 0);  cyc();
        ex(1, 0, 0, 0, 3'b001, 3, 0, 0);  kset(6'b000001, 0, 0);  cyc();
        ex(1, 0, 0, 0, 3'b001, 3, 0, 0);  kset(6'b000010, 0, 0);  cyc();
        ex(0, 0, 0, 0, 3'b000, 0, 0, 0);  cyc();

        // Load r5 then use on src1: one stall cycle, then forward from stage 2.
        ex(1, 1, 5, 1, 3'b000, 0, 0, 0);  kset(6'b000000, 0, 0);  cyc();
        ex(1, 0, 0, 0, 3'b010, 0, 5, 0);  kset(6'b000000, 1, 0);  cyc();
        ex(1, 0, 0, 0, 3'b010, 0, 5, 0);  kset(6'b001000, 0, 1);  cyc();

        // r2 in stages 1 and 2: youngest wins; unused source stays on regfile.
        ex(1, 1, 2, 0, 3'b000, 0, 0, 0);  cyc();
        ex(1, 1, 2, 0, 3'b000, 0, 0, 0);  cyc();
        ex(1, 0, 0, 0, 3'b101, 2, 0, 2);  kset(6'b010001, 0, 1);  cyc();
        ex(1, 0, 0, 0, 3'b001, 2, 0, 2);  kset(6'b000010, 0, 1);  cyc();

        // Interlock mode: r7 in stage 2 stalls; a frozen cycle holds everything.
        t_fwd_en = 0;
        ex(1, 1, 7, 0, 3'b000, 0, 0, 0);  cyc();
        ex(0, 0, 0, 0, 3'b000, 0, 0, 0);  cyc();
        ex(1, 0, 0, 0, 3'b001, 7, 0, 0);
        t_freeze = 1;  kset(6'b000000, 1, 1);  cyc();
        t_freeze = 0;  kset(6'b000000, 1, 1);  cyc();
        kset(6'b000000, 0, 2);  cyc();
        t_fwd_en = 1;

        // Load-use coinciding with flush: no stall and the flushed writer is dropped.
        ex(1, 1, 5, 1, 3'b000, 0, 0, 0);  cyc();
        t_flush = 1;
        ex(1, 1, 9, 0, 3'b010, 0, 5, 0);  kset(6'b000000, 0, 2);  cyc();
        t_flush = 0;
        ex(1, 0, 0, 0, 3'b011, 9, 5, 0);  kset(6'b001000, 0, 2);  cyc();

        // Ten more load-use stalls: build B saturates at 7.
        for (int i = 0; i < 10; i++) begin
            ex(1, 1, 5, 1, 3'b000, 0, 0, 0);  cyc();
            ex(1, 0, 0, 0, 3'b010, 0, 5, 0);  cyc();
            cyc();
        end
        ex(0, 0, 0, 0, 3'b000, 0, 0, 0);
        kset(6'b000000, 0, 12);  kb_en = 1;  k_cnt_b = 7;  cyc();

        // Random traffic on a small register window to provoke hazards.
        for (int n = 0; n < 2000; n++) begin
            t_rst    = ($urandom_range(0, 99) == 0);
            t_fwd_en = ($urandom_range(0, 3) != 0);
            t_freeze = ($urandom_range(0, 9) == 0);
            t_flush  = ($urandom_range(0, 9) == 0);
            ex($urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
               $urandom_range(0, 2) == 0, 3'($urandom),
               $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            cyc();
        end

        @(negedge clk);
        #5;
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL drain got %0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
